// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative
// chunked multiplier datapath.
package mult_pkg;

   localparam int CHUNK = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int nchunks(input int w);
      return w / CHUNK;
   endfunction

endpackage

// File: rtl/exact_mult_8bit.sv
// Exact unsigned 8x8 -> 16-bit combinational multiplier,
// the single partial-product engine of the datapath.
module exact_mult_8bit (
   input  logic [7:0]  i_a,
   input  logic [7:0]  i_b,
   output logic [15:0] o_p
);

   assign o_p = 16'(i_a) * 16'(i_b);

endmodule

// File: rtl/gated_iter_mult.sv
// Multi-cycle WxW multiplier: one 8x8 pair per cycle, with
// optional zero-gating of low-weight pairs in approx mode.
module gated_iter_mult
   import mult_pkg::*;
#(
   parameter int W     = 16,
   parameter int TRUNC = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic           approx,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] Y,
   output logic           busy
);

   localparam int K  = nchunks(W);
   localparam int KK = K * K;
   localparam int CW = (KK > 1) ? $clog2(KK) : 1;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam int PW = 2 * W;

   if (W % CHUNK != 0) begin : g_bad_mod
      $error("gated_iter_mult: W must be a multiple of 8");
   end
   if (W < 8 || W > 64) begin : g_bad_rng
      $error("gated_iter_mult: W must lie in 8..64");
   end
   if (TRUNC < 0 || TRUNC > 2 * K - 2) begin : g_bad_trunc
      $error("gated_iter_mult: TRUNC must lie in 0..2K-2");
   end

   state_t r_state;
   state_t w_next;

   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic          r_approx;
   logic [PW-1:0] r_acc;
   logic [PW-1:0] r_y;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_i;
   logic [IW-1:0] r_j;

   logic          w_ld;
   logic          w_calc;
   logic          w_fin;
   logic          w_last;
   logic          w_gate;
   logic [7:0]    w_ij;
   logic [10:0]   w_sh;
   logic [K-1:0][7:0] w_a_ch;
   logic [K-1:0][7:0] w_b_ch;
   logic [7:0]    w_ma;
   logic [7:0]    w_mb;
   logic [15:0]   w_pp;
   logic [PW-1:0] w_acc_nxt;

   assign w_last = (r_cnt == CW'(KK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_ld   = 1'b0;
      w_calc = 1'b0;
      w_fin  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_ld   = 1'b1;
               w_next = S_CALC;
            end
         end
         S_CALC: begin
            w_calc = 1'b1;
            if (w_last) begin
               w_fin  = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign Y         = r_y;

   assign w_a_ch = r_a;
   assign w_b_ch = r_b;
   assign w_ij   = 8'(r_i) + 8'(r_j);
   assign w_sh   = {w_ij, 3'b000};

   // Skipped pairs hold both multiplier inputs at zero so the array stays quiet
   assign w_gate = w_calc && !(r_approx && (w_ij < 8'(TRUNC)));
   assign w_ma   = w_gate ? w_a_ch[r_i] : 8'd0;
   assign w_mb   = w_gate ? w_b_ch[r_j] : 8'd0;

   exact_mult_8bit u_mul (
      .i_a (w_ma),
      .i_b (w_mb),
      .o_p (w_pp)
   );

   assign w_acc_nxt = r_acc + (PW'(w_pp) << w_sh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_approx <= 1'b0;
         r_acc    <= '0;
         r_y      <= '0;
         r_cnt    <= '0;
         r_i      <= '0;
         r_j      <= '0;
      end else begin
         if (w_ld) begin
            r_a      <= A;
            r_b      <= B;
            r_approx <= approx;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_i      <= '0;
            r_j      <= '0;
         end else if (w_calc) begin
            r_acc <= w_acc_nxt;
            if (!w_last) begin
               r_cnt <= r_cnt + 1'b1;
               if (r_i == IW'(K - 1)) begin
                  r_i <= '0;
                  r_j <= r_j + 1'b1;
               end else begin
                  r_i <= r_i + 1'b1;
               end
            end
         end
         if (w_fin) begin
            r_y <= w_acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_gated_iter_mult.sv
// Self-checking bench: directed W=16 cases plus random W=32
// and W=8 runs against an arithmetic reference model.
`timescale 1ns/1ps
module tb_gated_iter_mult;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // W=16, TRUNC=1
   logic        v16 = 0, rdy16, ap16 = 0, ov16, or16 = 0, busy16;
   logic [15:0] a16 = 0, b16 = 0;
   logic [31:0] y16;
   // W=32
   logic        v32 = 0, rdy32, ov32, or32 = 0, busy32;
   logic [31:0] a32 = 0, b32 = 0;
   logic [63:0] y32;
   // W=8
   logic        v8 = 0, rdy8, ov8, or8 = 0, busy8;
   logic [7:0]  a8 = 0, b8 = 0;
   logic [15:0] y8;

   gated_iter_mult #(.W(16), .TRUNC(1)) d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
      .A(a16), .B(b16), .approx(ap16), .out_valid(ov16),
      .out_ready(or16), .Y(y16), .busy(busy16));

   gated_iter_mult #(.W(32), .TRUNC(1)) d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
      .A(a32), .B(b32), .approx(1'b0), .out_valid(ov32),
      .out_ready(or32), .Y(y32), .busy(busy32));

   gated_iter_mult #(.W(8), .TRUNC(0)) d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
      .A(a8), .B(b8), .approx(1'b0), .out_valid(ov8),
      .out_ready(or8), .Y(y8), .busy(busy8));

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Product minus every pair product whose weight i+j is below trunc
   function automatic logic [31:0] model16(input logic [15:0] a,
         input logic [15:0] b, input logic ap, input int trunc);
      logic [31:0] y;
      logic [15:0] ta, tb;
      y = 32'(a) * 32'(b);
      if (ap) begin
         for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
               if (i + j < trunc) begin
                  ta = a >> (8 * i);
                  tb = b >> (8 * j);
                  y = y - ((32'(ta[7:0]) * 32'(tb[7:0])) << (8 * (i + j)));
               end
            end
         end
      end
      return y;
   endfunction

   // Drive one transaction and leave the bench #1 after the accept edge
   task automatic start16(input logic [15:0] a, input logic [15:0] b,
                          input logic ap);
      logic [15:0] t;
      chk("rdy16_before", rdy16, 1'b1);
      a16 = a; b16 = b; ap16 = ap; v16 = 1'b1;
      @(posedge clk); #1;
      v16 = 1'b0;
      t = a;
      chk("mul_a_cnt0", d16.u_mul.i_a, ap ? 8'd0 : t[7:0]);
      t = b;
      chk("mul_b_cnt0", d16.u_mul.i_b, ap ? 8'd0 : t[7:0]);
   endtask

   task automatic wait16(input logic [31:0] ey);
      int lat;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ov16 && lat < 50);
      chk("lat16", 32'(lat), 32'd4);
      chk("y16", y16, ey);
   endtask

   task automatic release16();
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      chk("ov16_fall", ov16, 1'b0);
      chk("rdy16_rise", rdy16, 1'b1);
   endtask

   task automatic txn16(input logic [15:0] a, input logic [15:0] b,
                        input logic ap);
      start16(a, b, ap);
      wait16(model16(a, b, ap, 1));
      release16();
   endtask

   logic [31:0] y_hold;

   initial begin
      #2;
      chk("rst_rdy", rdy16, 1'b1);
      chk("rst_ov", ov16, 1'b0);
      chk("rst_busy", busy16, 1'b0);
      chk("rst_y", y16, 32'd0);
      chk("rst_y32", y32, 64'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      start16(16'h1234, 16'h5678, 1'b0);
      wait16(32'h0626_0060);
      release16();

      txn16(16'hFFFF, 16'hFFFF, 1'b0);
      chk("ffff_exact", y16, 32'hFFFE_0001);
      txn16(16'hFFFF, 16'hFFFF, 1'b1);
      chk("ffff_approx", y16, 32'hFFFD_0200);

      for (int n = 0; n < 20; n++) begin
         txn16(16'($urandom), 16'($urandom), 1'($urandom));
      end

      // Backpressure with a stray request while DONE
      start16(16'hABCD, 16'h1357, 1'b0);
      wait16(model16(16'hABCD, 16'h1357, 1'b0, 1));
      y_hold = y16;
      a16 = 16'h0101; b16 = 16'h0202; v16 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp_y", y16, y_hold);
         chk("bp_ov", ov16, 1'b1);
         chk("bp_rdy", rdy16, 1'b0);
      end
      v16 = 1'b0;
      release16();
      chk("bp_busy", busy16, 1'b0);
      start16(16'd3, 16'd5, 1'b0);
      wait16(32'd15);
      release16();

      // Asynchronous reset at cnt=2
      start16(16'hFFFF, 16'hFFFF, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_busy", busy16, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_rdy", rdy16, 1'b1);
      chk("ar_ov", ov16, 1'b0);
      chk("ar_busy", busy16, 1'b0);
      chk("ar_y", y16, 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_y", y16, 32'd0);
      txn16(16'hFFFF, 16'h0001, 1'b0);
      chk("post_ffff", y16, 32'h0000_FFFF);

      fork
         begin
            logic [31:0] ra, rb;
            int lat;
            for (int n = 0; n < 1000; n++) begin
               ra = $urandom; rb = $urandom;
               a32 = ra; b32 = rb; v32 = 1'b1;
               @(posedge clk); #1;
               v32 = 1'b0;
               lat = 0;
               do begin
                  @(posedge clk); #1;
                  lat++;
               end while (!ov32 && lat < 50);
               chk("lat32", 32'(lat), 32'd16);
               chk("y32", y32, 64'(ra) * 64'(rb));
               or32 = 1'b1;
               @(posedge clk); #1;
               or32 = 1'b0;
            end
         end
         begin
            logic [7:0] ra, rb;
            int lat;
            for (int n = 0; n < 1000; n++) begin
               ra = 8'($urandom); rb = 8'($urandom);
               a8 = ra; b8 = rb; v8 = 1'b1;
               @(posedge clk); #1;
               v8 = 1'b0;
               lat = 0;
               do begin
                  @(posedge clk); #1;
                  lat++;
               end while (!ov8 && lat < 50);
               chk("lat8", 32'(lat), 32'd1);
               chk("y8", y8, 16'(ra) * 16'(rb));
               or8 = 1'b1;
               @(posedge clk); #1;
               or8 = 1'b0;
            end
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gated_iter_mult.md
# gated_iter_mult

Parametrised, multi-cycle W×W unsigned multiplier that reuses one 8×8 exact partial-product multiplier for every chunk pair. It accumulates the pairs serially and exposes valid/ready handshakes on both sides. A per-transaction approximate mode zero-gates low-weight partial products to cut switching power while keeping latency fixed. It is the successor to the fixed 16-bit four-instance combinational multiplier and sits between operand staging and the result FIFO in the multiplier datapath.

## Interface
- W, default 16: operand width; must be a multiple of 8, range 8..64.
- TRUNC, default 1: in approximate mode, chunk pairs (i,j) with i+j < TRUNC are skipped; range 0..2K-2, where K = W/8.
- clk  in  1: clock. One clock domain only.
- rst_n  in  1: reset. Asynchronous assertion, active-low.
- in_valid  in  1: operands A, B and approx are valid.
- in_ready  out  1: block can accept operands.
- A  in  W: multiplicand, unsigned.
- B  in  W: multiplier, unsigned.
- approx  in  1: 1 selects approximate mode for this transaction. Sampled only at accept.
- out_valid  out  1: Y holds a completed result.
- out_ready  in  1: consumer accepts Y.
- Y  out  2W: product.
- busy  out  1: high in CALC and DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: one chunk pair per cycle.
  - DONE: out_valid=1, Y stable.
- Accept = in_valid && in_ready, IDLE only. On accept:
  - register A, B and approx;
  - clear the 2W-bit accumulator;
  - cnt←0;
  - go to CALC.
- CALC, pair ordering: cnt runs 0..K·K−1, with i = cnt mod K (A chunk) and j = cnt / K (B chunk).
- CALC, per-cycle partial product: pp = A[8i+7:8i] × B[8j+7:8j], 16 bits.
- CALC, accumulation: acc += pp << 8(i+j). Width is 2W; no overflow is possible, and the final sum is exact modulo 2^2W.
- Approximate mode: if approx_r=1 and i+j < TRUNC, both operands of the 8×8 multiplier are forced to 0, so no toggling occurs and pp=0. The cycle is still consumed.
- Exact mode: all pairs are accumulated; Y = A×B.
- Approximate mode result: Y = A×B − Σ skipped pp. TRUNC=0 is identical to exact mode.
- When cnt = K·K−1 and its pair has been accumulated, go to DONE.
- DONE: Y = acc, held. On out_ready=1, go to IDLE.
- When not in CALC:
  - operand registers and the accumulator hold, with the enable deasserted;
  - the multiplier inputs are held at 0.
- Y holds its last value in IDLE. Consumers must qualify it with out_valid.
- in_valid while busy: ignored; in_ready=0. Upstream must hold its data.
- Reset mid-CALC or mid-DONE: the transaction is discarded and there is no partial output.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, Y=0, acc=0, cnt=0.
- Accept edge E0. Accumulation edges are E1..E(K·K). out_valid rises after E(K·K).
  - Latency is K·K cycles from accept: 4 for W=16, 1 for W=8, 16 for W=32.
  - Latency does not depend on approx.
- Release: out_valid falls on the first edge where out_ready=1.
  - in_ready rises on that same edge, so a new accept can occur in the next cycle.
  - Minimum initiation interval is K·K+2 cycles.
- out_ready held high before DONE: DONE still lasts at least one cycle, and out_valid is visible for one cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Critical path: 8×8 multiply, then a 2W-bit shift-add, then the acc register.

## Structure
- Package mult_pkg contains:
  - the state typedef (IDLE, CALC, DONE);
  - localparam CHUNK=8;
  - helper function nchunks(W)=W/CHUNK.
- Sub-module: a single instance of exact_mult_8bit (8×8 to 16-bit, combinational), with gated operand inputs.
- The top level contains the FSM, cnt, operand and approx registers, the shift-add and the accumulator.
- Elaboration checks:
  - assert W%8==0;
  - assert 8 ≤ W ≤ 64;
  - assert TRUNC ≤ 2K−2.

## Test plan
- W=16, exact, A=0x1234, B=0x5678 → Y=0x06260060, with out_valid exactly 4 cycles after accept.
- W=16, A=B=0xFFFF:
  - exact → Y=0xFFFE0001;
  - approx=1, TRUNC=1 → Y=0xFFFD0200, still 4-cycle latency;
  - approx cycle: the 8×8 multiplier inputs are 0 during the cnt=0 cycle.
- Backpressure: hold out_ready=0 for 10 cycles after DONE.
  - Y is stable and out_valid stays high;
  - in_ready=0 and a new in_valid is ignored;
  - out_ready pulse → IDLE, then back-to-back accept of A=3, B=5 → Y=15.
- Reset: drive rst_n low at cnt=2 of a W=16 transaction.
  - All outputs go to reset values immediately, without waiting for a clock edge;
  - after release, a fresh transaction with A=0xFFFF, B=1 → Y=0x0000FFFF.
- W=32 and W=8 builds, 1000 random operands, exact mode → Y equals A×B, with latency 16 and 1 respectively.
